// File: rtl/div_pkg.sv
// Shared types and constants for the divider scheduler and its iterative divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_WAIT1,
        ST_ISSUE2,
        ST_WAIT2,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_QUO  = 2'b00,
        OP_REM  = 2'b01,
        OP_BOTH = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    // Operands latched at acceptance and held on the divider for the whole run
    typedef struct packed {
        logic [DIV_WIDTH-1:0] a;
        logic [DIV_WIDTH-1:0] b;
        logic                 divs;
        op_t                  op;
    } div_req_t;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per cycle, no reset of its own.
// The signed result is formed combinationally from the live inputs on top of the magnitude core.
module divider
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 go,
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    input  logic                 divs,
    input  logic                 remainder,
    output logic [DIV_WIDTH-1:0] c,
    output logic                 available,
    output logic                 is_zero,
    output logic                 is_negative
);

    logic [DIV_WIDTH-1:0] rem_q;
    logic [DIV_WIDTH-1:0] quo_q;
    logic [DIV_WIDTH-1:0] bmag_q;
    logic [5:0]           cnt_q;
    logic                 run_q;
    logic                 avail_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [DIV_WIDTH-1:0] amag;
    logic [DIV_WIDTH-1:0] bmag;
    logic [DIV_WIDTH:0]   trial;
    logic                 fits;
    logic [DIV_WIDTH-1:0] res_mag;
    logic                 res_neg;

    always_comb begin
        a_neg   = divs & a[DIV_WIDTH-1];
        b_neg   = divs & b[DIV_WIDTH-1];
        amag    = a_neg ? (~a + 32'd1) : a;
        bmag    = b_neg ? (~b + 32'd1) : b;
        trial   = {rem_q, quo_q[DIV_WIDTH-1]};
        fits    = trial >= {1'b0, bmag_q};
        res_mag = remainder ? rem_q : quo_q;
        res_neg = remainder ? a_neg : (a_neg ^ b_neg);
        c       = res_neg ? (~res_mag + 32'd1) : res_mag;
    end

    assign available   = avail_q;
    assign is_zero     = (c == '0);
    assign is_negative = c[DIV_WIDTH-1];

    // A zero divisor skips the iterations so the caller can substitute quickly
    always_ff @(posedge clk) begin
        avail_q <= 1'b0;
        if (go) begin
            rem_q  <= '0;
            quo_q  <= amag;
            bmag_q <= bmag;
            cnt_q  <= (b == '0) ? 6'd0 : 6'd32;
            run_q  <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == 6'd0) begin
                run_q   <= 1'b0;
                avail_q <= 1'b1;
            end else begin
                rem_q <= fits ? (trial[DIV_WIDTH-1:0] - bmag_q) : trial[DIV_WIDTH-1:0];
                quo_q <= {quo_q[DIV_WIDTH-2:0], fits};
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Two-port round-robin front end sharing one iterative divider; sequences single and fused
// quotient/remainder runs, substitutes divide-by-zero results and aborts stuck runs.
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned TIMEOUT = 96
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][DIV_WIDTH-1:0] req_a,
    input  logic [1:0][DIV_WIDTH-1:0] req_b,
    input  logic [1:0]                req_divs,
    input  logic [1:0][1:0]           req_op,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [1:0][DIV_WIDTH-1:0] rsp_data,
    output logic [1:0][DIV_WIDTH-1:0] rsp_rem,
    output logic [1:0]                rsp_zero,
    output logic [1:0]                rsp_neg,
    output logic [1:0]                rsp_dbz,
    output logic [1:0]                rsp_err,
    output logic                      busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    div_req_t             lat_q;
    logic                 owner_q;
    logic                 prio_q;
    logic                 dbz_q;
    logic [WD_W-1:0]      wd_q;
    logic [DIV_WIDTH-1:0] q_data;
    logic [DIV_WIDTH-1:0] q_rem;
    logic                 q_zero;
    logic                 q_neg;

    logic                 winner_c;
    logic                 accept_c;
    logic                 div_go_c;
    logic                 div_rem_c;
    logic                 cap1_c;
    logic                 cap2_c;
    logic                 abort_c;
    logic                 load_resp_c;
    logic                 resp_done_c;
    logic                 wd_clr_c;
    logic                 wd_inc_c;
    logic                 wd_expired_c;

    logic [DIV_WIDTH-1:0] fin_data_c;
    logic [DIV_WIDTH-1:0] fin_rem_c;
    logic                 fin_zero_c;
    logic                 fin_neg_c;
    logic                 fin_dbz_c;

    logic [DIV_WIDTH-1:0] div_c;
    logic                 div_avail;
    logic                 div_zero;
    logic                 div_neg;

    // prio_q names the port that wins a tie; it moves away from each completed owner
    always_comb begin
        winner_c = prio_q;
        if (req_valid == 2'b01)      winner_c = 1'b0;
        else if (req_valid == 2'b10) winner_c = 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && req_valid[winner_c] && !rsp_valid[winner_c])
            req_ready[winner_c] = 1'b1;
    end

    assign accept_c     = |(req_valid & req_ready);
    assign wd_expired_c = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        div_go_c    = 1'b0;
        div_rem_c   = (lat_q.op == OP_REM);
        cap1_c      = 1'b0;
        cap2_c      = 1'b0;
        abort_c     = 1'b0;
        load_resp_c = 1'b0;
        resp_done_c = 1'b0;
        wd_clr_c    = 1'b0;
        wd_inc_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                div_go_c = 1'b1;
                wd_clr_c = 1'b1;
                state_d  = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (div_avail) begin
                    cap1_c = 1'b1;
                    if (lat_q.op == OP_BOTH) begin
                        state_d = ST_ISSUE2;
                    end else begin
                        load_resp_c = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else if (wd_expired_c) begin
                    abort_c     = 1'b1;
                    load_resp_c = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_inc_c = 1'b1;
                end
            end
            ST_ISSUE2: begin
                div_go_c  = 1'b1;
                div_rem_c = 1'b1;
                wd_clr_c  = 1'b1;
                state_d   = ST_WAIT2;
            end
            ST_WAIT2: begin
                div_rem_c = 1'b1;
                if (div_avail) begin
                    cap2_c      = 1'b1;
                    load_resp_c = 1'b1;
                    state_d     = ST_RESP;
                end else if (wd_expired_c) begin
                    abort_c     = 1'b1;
                    load_resp_c = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_inc_c = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    resp_done_c = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response payload as it will be registered on entry to RESP
    always_comb begin
        fin_data_c = cap1_c ? div_c : q_data;
        fin_zero_c = cap1_c ? div_zero : q_zero;
        fin_neg_c  = cap1_c ? div_neg : q_neg;
        fin_rem_c  = '0;
        fin_dbz_c  = dbz_q;
        if (lat_q.op == OP_BOTH) fin_rem_c = cap2_c ? div_c : q_rem;
        if (dbz_q) begin
            fin_data_c = (lat_q.op == OP_REM) ? lat_q.a : DBZ_QUOTIENT;
            if (lat_q.op == OP_BOTH) fin_rem_c = lat_q.a;
            fin_zero_c = (fin_data_c == '0);
            fin_neg_c  = fin_data_c[DIV_WIDTH-1];
        end
        if (abort_c) begin
            fin_data_c = '0;
            fin_rem_c  = '0;
            fin_zero_c = 1'b0;
            fin_neg_c  = 1'b0;
            fin_dbz_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q     <= '0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            dbz_q     <= 1'b0;
            wd_q      <= '0;
            q_data    <= '0;
            q_rem     <= '0;
            q_zero    <= 1'b0;
            q_neg     <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_rem   <= '0;
            rsp_zero  <= '0;
            rsp_neg   <= '0;
            rsp_dbz   <= '0;
            rsp_err   <= '0;
        end else begin
            if (accept_c) begin
                lat_q.a    <= req_a[winner_c];
                lat_q.b    <= req_b[winner_c];
                lat_q.divs <= req_divs[winner_c];
                lat_q.op   <= (req_op[winner_c] == OP_RSVD) ? OP_QUO : op_t'(req_op[winner_c]);
                owner_q    <= winner_c;
                dbz_q      <= (req_b[winner_c] == '0);
                busy       <= 1'b1;
            end
            if (wd_clr_c)      wd_q <= '0;
            else if (wd_inc_c) wd_q <= wd_q + WD_W'(1);
            if (cap1_c) begin
                q_data <= div_c;
                q_zero <= div_zero;
                q_neg  <= div_neg;
            end
            if (cap2_c) q_rem <= div_c;
            if (resp_done_c) begin
                busy      <= 1'b0;
                prio_q    <= ~owner_q;
                rsp_valid <= '0;
                rsp_data  <= '0;
                rsp_rem   <= '0;
                rsp_zero  <= '0;
                rsp_neg   <= '0;
                rsp_dbz   <= '0;
                rsp_err   <= '0;
            end else if (load_resp_c) begin
                rsp_valid[owner_q] <= 1'b1;
                rsp_data[owner_q]  <= fin_data_c;
                rsp_rem[owner_q]   <= fin_rem_c;
                rsp_zero[owner_q]  <= fin_zero_c;
                rsp_neg[owner_q]   <= fin_neg_c;
                rsp_dbz[owner_q]   <= fin_dbz_c;
                rsp_err[owner_q]   <= abort_c;
            end
        end
    end

    divider u_divider (
        .clk         (clk),
        .go          (div_go_c),
        .a           (lat_q.a),
        .b           (lat_q.b),
        .divs        (lat_q.divs),
        .remainder   (div_rem_c),
        .c           (div_c),
        .available   (div_avail),
        .is_zero     (div_zero),
        .is_negative (div_neg)
    );

endmodule
